// File: rtl/barrel_pkg.sv
// barrel_pkg: shared widths, types and a reference
// model for the shift-OR datapath stage.
package barrel_pkg;

  localparam int WIDTH = 8;
  localparam int SEL_W = 3;

  typedef logic [WIDTH-1:0] data_t;
  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic {
    DIR_LEFT,
    DIR_RIGHT
  } dir_e;

  function automatic data_t shift_or(
    data_t d,
    sel_t  s
  );
    return (d << s) | (d >> s);
  endfunction

endpackage

// File: rtl/barrel_log_shifter.sv
// barrel_log_shifter: combinational logical shifter,
// one stage per sel bit (shift by 1, 2, 4).
module barrel_log_shifter
  import barrel_pkg::*;
#(
  parameter dir_e DIR = DIR_LEFT
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] stage [SEL_W+1];

  assign stage[0] = data_in;

  for (genvar i = 0; i < SEL_W; i++) begin : g_stage
    if (DIR == DIR_LEFT) begin : g_left
      assign stage[i+1] = sel[i]
        ? (stage[i] << (1 << i))
        : stage[i];
    end else begin : g_right
      assign stage[i+1] = sel[i]
        ? (stage[i] >> (1 << i))
        : stage[i];
    end
  end

  assign data_out = stage[SEL_W];

endmodule

// File: rtl/barrel_shift_or.sv
// barrel_shift_or: load-enabled register capturing
// (d << s) | (d >> s); bits past either end drop.
module barrel_shift_or
  import barrel_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             Load,
  input  logic [SEL_W-1:0] sel,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] left;
  logic [WIDTH-1:0] right;
  logic [WIDTH-1:0] combined;

  barrel_log_shifter #(
    .DIR(DIR_LEFT)
  ) u_left (
    .data_in (data_in),
    .sel     (sel),
    .data_out(left)
  );

  barrel_log_shifter #(
    .DIR(DIR_RIGHT)
  ) u_right (
    .data_in (data_in),
    .sel     (sel),
    .data_out(right)
  );

  assign combined = left | right;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out <= '0;
    end else if (Load) begin
      data_out <= combined;
    end
  end

endmodule

// File: tb/tb_barrel_shift_or.sv
// tb_barrel_shift_or: directed vectors against an
// independent per-bit reference of the shift-OR stage.
module tb_barrel_shift_or;

  logic       clk;
  logic       reset;
  logic       Load;
  logic [2:0] sel;
  logic [7:0] data_in;
  logic [7:0] data_out;

  int n_cmp;
  int n_bad;

  barrel_shift_or dut (
    .clk     (clk),
    .reset   (reset),
    .Load    (Load),
    .sel     (sel),
    .data_in (data_in),
    .data_out(data_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(
    input string      tag,
    input logic [7:0] got,
    input logic [7:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h want %02h",
               tag, got, exp);
    end
  endtask

  // bit k = d[k-s] (k>=s) | d[k+s] (k+s<8)
  function automatic logic [7:0] ref_f(
    input logic [7:0] d,
    input int         s
  );
    logic [7:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      if (k >= s && d[k-s]) r[k] = 1'b1;
      if (k + s < 8 && d[k+s]) r[k] = 1'b1;
    end
    return r;
  endfunction

  task automatic cap(
    input string      tag,
    input logic [7:0] d,
    input logic [2:0] s,
    input logic [7:0] exp
  );
    Load    = 1'b1;
    data_in = d;
    sel     = s;
    @(posedge clk);
    #1;
    check(tag, data_out, exp);
  endtask

  logic [7:0] sweep_d [3];

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    reset   = 1'b1;
    Load    = 1'b0;
    sel     = 3'd0;
    data_in = 8'h00;
    sweep_d[0] = 8'h3D;
    sweep_d[1] = 8'hC6;
    sweep_d[2] = 8'h9B;

    #2;
    reset   = 1'b0;
    Load    = 1'b1;
    data_in = 8'hFF;
    sel     = 3'd3;
    #1;
    check("rst_async", data_out, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold", data_out, 8'h00);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_release", data_out, 8'hFF);

    cap("ident", 8'hA5, 3'd0, 8'hA5);
    cap("a5_s1", 8'hA5, 3'd1, 8'h5A);
    cap("a5_s4", 8'hA5, 3'd4, 8'h5A);
    cap("01_s3", 8'h01, 3'd3, 8'h08);
    cap("81_s7", 8'h81, 3'd7, 8'h81);
    cap("ff_s2", 8'hFF, 3'd2, 8'hFF);
    cap("80_s7", 8'h80, 3'd7, 8'h01);
    cap("3c_s2", 8'h3C, 3'd2, 8'hFF);

    for (int v = 0; v < 3; v++) begin
      for (int s = 0; s < 8; s++) begin
        cap($sformatf("sweep_%02h_s%0d",
                      sweep_d[v], s),
            sweep_d[v], 3'(s),
            ref_f(sweep_d[v], s));
      end
    end

    cap("hold_cap", 8'h3C, 3'd0, 8'h3C);
    Load = 1'b0;
    for (int c = 0; c < 5; c++) begin
      data_in = 8'(8'h11 * (c + 1));
      sel     = 3'(c + 1);
      @(posedge clk);
      #1;
      check($sformatf("hold_%0d", c),
            data_out, 8'h3C);
    end

    cap("pre_rst", 8'hA5, 3'd1, 8'h5A);
    data_in = 8'hFF;
    sel     = 3'd0;
    #3;
    reset = 1'b0;
    #1;
    check("rst_mid", data_out, 8'h00);
    @(posedge clk);
    #1;
    check("rst_mid_edge", data_out, 8'h00);
    reset = 1'b1;
    Load  = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_noload", data_out, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
